spi_flash_sched: RTL and testbench

- Two-requester scheduler in front of the single SPI_Master flash engine. Requester 0 is the boot/read path; requester 1 is the config/write path.
- Arbitrates requests round-robin and drives the master's enable, commands, Address and data_out.
- Auto-inserts a Write-Enable (WREN) transaction before every program command.
- Enforces a minimum CS-high gap between transactions and a completion timeout.

---
 rtl/spi_flash_sched_if.sv | 40 ++++
 rtl/spi_flash_sched.sv | 171 +++++++++++++++++
 tb/tb_spi_flash_sched.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_sched_if.sv
// spi_flash_sched_if
//   Bundles the two requester ports and the SPI master engine port of the
//   flash scheduler.
//   master modport : the scheduler side (accepts requests, drives the engine)
//   slave  modport : the environment side (requesters + SPI master engine)
//
//   Handshakes:
//     reqN is a level held high until ackN; ackN is a one-cycle pulse and
//     errN/rdataN are valid in that same cycle (rdataN holds afterwards).
//     m_enable is a level held for the whole engine transaction; m_done is a
//     one-cycle pulse from the engine with m_rdata valid in that cycle.
interface spi_flash_sched_if;
    logic        req0, req1;
    logic [7:0]  cmd0, cmd1;
    logic [23:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic        err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        m_enable;
    logic [7:0]  m_commands;
    logic [23:0] m_address;
    logic [31:0] m_data_out;
    logic        m_done;
    logic [31:0] m_rdata;

    modport master (
        input  req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1,
        input  m_done, m_rdata,
        output ack0, ack1, err0, err1, rdata0, rdata1,
        output m_enable, m_commands, m_address, m_data_out
    );

    modport slave (
        output req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1,
        output m_done, m_rdata,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
        input  m_enable, m_commands, m_address, m_data_out
    );
endinterface

// File: rtl/spi_flash_sched.sv
// spi_flash_sched
//   Round-robin scheduler for two flash requesters (0 = boot/read path,
//   1 = config/write path) in front of a single SPI master engine.
//   A write-enable transaction is inserted ahead of every program command,
//   a minimum m_enable-low gap is kept between engine transactions, and each
//   engine transaction is aborted if m_done does not arrive within TIMEOUT.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : requester + engine signals (spi_flash_sched_if.master)
//   state_dbg  : current FSM state, for observation only
module spi_flash_sched #(
    parameter logic [7:0] WREN_CMD   = 8'h06,
    parameter logic [7:0] PROG_CMD   = 8'h02,
    parameter int         GAP_CYCLES = 4,
    parameter int         TIMEOUT    = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    spi_flash_sched_if.master         bus,
    output logic [2:0]                state_dbg
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WREN_RUN = 3'd1;
    localparam logic [2:0] ST_GAP      = 3'd2;
    localparam logic [2:0] ST_XFER_RUN = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    localparam logic [3:0]  GAP_LOAD = 4'(GAP_CYCLES);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state;
    logic        rr_last;
    logic [3:0]  gap_cnt;
    logic [15:0] tmo_cnt;
    logic        lat_id;
    logic [7:0]  lat_cmd;
    logic [23:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        grant_id;
    logic [7:0]  win_cmd;
    logic [23:0] win_addr;
    logic [31:0] win_wdata;
    logic        tmo_hit;

    assign state_dbg = state;
    // tmo_cnt counts completed high cycles; this is the last high cycle allowed.
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // With both requesting, the one that was not served last wins.
    always_comb begin
        grant_id  = (bus.req0 && bus.req1) ? ~rr_last : bus.req1;
        win_cmd   = grant_id ? bus.cmd1   : bus.cmd0;
        win_addr  = grant_id ? bus.addr1  : bus.addr0;
        win_wdata = grant_id ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            rr_last        <= 1'b1;
            gap_cnt        <= 4'd0;
            tmo_cnt        <= 16'd0;
            lat_id         <= 1'b0;
            lat_cmd        <= 8'd0;
            lat_addr       <= 24'd0;
            lat_wdata      <= 32'd0;
            bus.ack0       <= 1'b0;
            bus.ack1       <= 1'b0;
            bus.err0       <= 1'b0;
            bus.err1       <= 1'b0;
            bus.rdata0     <= 32'd0;
            bus.rdata1     <= 32'd0;
            bus.m_enable   <= 1'b0;
            bus.m_commands <= 8'd0;
            bus.m_address  <= 24'd0;
            bus.m_data_out <= 32'd0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.err0 <= 1'b0;
            bus.err1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else if (bus.req0 || bus.req1) begin
                        lat_id       <= grant_id;
                        lat_cmd      <= win_cmd;
                        lat_addr     <= win_addr;
                        lat_wdata    <= win_wdata;
                        tmo_cnt      <= 16'd0;
                        bus.m_enable <= 1'b1;
                        if (win_cmd == PROG_CMD) begin
                            state          <= ST_WREN_RUN;
                            bus.m_commands <= WREN_CMD;
                            bus.m_address  <= 24'd0;
                            bus.m_data_out <= 32'd0;
                        end else begin
                            state          <= ST_XFER_RUN;
                            bus.m_commands <= win_cmd;
                            bus.m_address  <= win_addr;
                            bus.m_data_out <= win_wdata;
                        end
                    end
                end
                ST_WREN_RUN: begin
                    if (bus.m_done) begin
                        bus.m_enable <= 1'b0;
                        gap_cnt      <= GAP_LOAD;
                        state        <= ST_GAP;
                    end else if (tmo_hit) begin
                        // Aborted write-enable: the program transfer is skipped.
                        bus.m_enable <= 1'b0;
                        bus.ack0     <= ~lat_id;
                        bus.ack1     <= lat_id;
                        bus.err0     <= ~lat_id;
                        bus.err1     <= lat_id;
                        state        <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    // Entered with GAP_CYCLES loaded; leaving on the count of 1
                    // keeps m_enable low for exactly GAP_CYCLES cycles.
                    if (gap_cnt <= 4'd1) begin
                        gap_cnt        <= 4'd0;
                        tmo_cnt        <= 16'd0;
                        bus.m_enable   <= 1'b1;
                        bus.m_commands <= lat_cmd;
                        bus.m_address  <= lat_addr;
                        bus.m_data_out <= lat_wdata;
                        state          <= ST_XFER_RUN;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                ST_XFER_RUN: begin
                    if (bus.m_done) begin
                        bus.m_enable <= 1'b0;
                        bus.ack0     <= ~lat_id;
                        bus.ack1     <= lat_id;
                        if (lat_id) bus.rdata1 <= bus.m_rdata;
                        else        bus.rdata0 <= bus.m_rdata;
                        state        <= ST_RESP;
                    end else if (tmo_hit) begin
                        bus.m_enable <= 1'b0;
                        bus.ack0     <= ~lat_id;
                        bus.ack1     <= lat_id;
                        bus.err0     <= ~lat_id;
                        bus.err1     <= lat_id;
                        state        <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    // ackN is high during this cycle (set on entry).
                    rr_last <= lat_id;
                    gap_cnt <= GAP_LOAD;
                    state   <= ST_IDLE;
                end
                default: begin
                    bus.m_enable <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_sched.sv
module tb_spi_flash_sched;
    localparam int         GAP  = 4;
    localparam int         TMO  = 4096;
    localparam logic [7:0] WREN = 8'h06;
    localparam logic [7:0] PROG = 8'h02;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state_dbg;

    spi_flash_sched_if bus();

    spi_flash_sched #(
        .WREN_CMD(WREN), .PROG_CMD(PROG), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.master), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Expected engine transaction; hi_len < 0 means "length not checked",
    // gap_exact means the preceding low time must equal GAP exactly.
    typedef struct { logic [7:0] cmd; logic [23:0] addr; logic [31:0] data; int hi_len; bit gap_exact; } txn_t;
    // Engine behaviour for one transaction: m_done in the lat-th high cycle (0 = never).
    typedef struct { int lat; logic [31:0] rdata; } plan_t;
    typedef struct { logic id; logic err; logic [31:0] rdata; } ack_t;

    txn_t  exp_txn_q[$];
    plan_t plan_q[$];
    ack_t  exp_ack_q[$];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_rdata [2];
    int          model_last = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: what a request should turn into on the engine and at the ack.
    task automatic expect_req(input int id, input logic [7:0] cmd, input logic [23:0] addr,
                              input logic [31:0] wdata, input int lat_w, input int lat_x,
                              input logic [31:0] rd);
        bit   aborted = 0;
        bit   exact   = 0;
        ack_t a;
        if (cmd == PROG) begin
            exp_txn_q.push_back('{WREN, 24'd0, 32'd0, (lat_w == 0) ? TMO : lat_w, 1'b0});
            plan_q.push_back('{lat_w, $urandom});
            aborted = (lat_w == 0);
            exact   = 1;
        end
        if (!aborted) begin
            exp_txn_q.push_back('{cmd, addr, wdata, (lat_x == 0) ? TMO : lat_x, exact});
            plan_q.push_back('{lat_x, rd});
        end
        a.id  = id[0];
        a.err = aborted || (lat_x == 0);
        if (!a.err) model_rdata[id] = rd;
        a.rdata = model_rdata[id];
        exp_ack_q.push_back(a);
        model_last = id;
    endtask

    task automatic set_fields(input int id, input logic [7:0] c, input logic [23:0] a, input logic [31:0] w);
        if (id == 0) begin bus.cmd0 = c; bus.addr0 = a; bus.wdata0 = w; end
        else         begin bus.cmd1 = c; bus.addr1 = a; bus.wdata1 = w; end
    endtask

    // Drop each request on its ack; optionally scramble a granted single requester's inputs.
    task automatic wait_acks(input bit need0, input bit need1, input bit scramble);
        int budget = 3 * TMO + 400;
        while ((need0 || need1) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.ack0 && need0) begin bus.req0 = 1'b0; need0 = 0; end
            if (bus.ack1 && need1) begin bus.req1 = 1'b0; need1 = 0; end
            if (scramble && bus.m_enable) begin
                if (need0) set_fields(0, 8'($urandom), 24'($urandom), $urandom);
                if (need1) set_fields(1, 8'($urandom), 24'($urandom), $urandom);
            end
        end
        if (need0 || need1) begin
            check("ack_wait_expired", 64'(budget), 64'd1);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
    endtask

    task automatic do_single(input int id, input logic [7:0] c, input logic [23:0] a, input logic [31:0] w,
                             input int lw, input int lx, input logic [31:0] rd);
        @(negedge clk);
        expect_req(id, c, a, w, lw, lx, rd);
        set_fields(id, c, a, w);
        if (id == 0) bus.req0 = 1'b1; else bus.req1 = 1'b1;
        wait_acks(id == 0, id == 1, 1'b1);
    endtask

    task automatic do_pair(input logic [7:0] c0, input logic [7:0] c1, input int lx0, input int lx1);
        int          w = (model_last == 0) ? 1 : 0;
        logic [23:0] a [2];
        logic [31:0] d [2];
        logic [31:0] r [2];
        logic [7:0]  c [2];
        c[0] = c0; c[1] = c1;
        for (int i = 0; i < 2; i++) begin a[i] = 24'($urandom); d[i] = $urandom; r[i] = $urandom; end
        expect_req(w,     c[w],     a[w],     d[w],     $urandom_range(1, 30), lx0, r[w]);
        expect_req(1 - w, c[1 - w], a[1 - w], d[1 - w], $urandom_range(1, 30), lx1, r[1 - w]);
        set_fields(0, c[0], a[0], d[0]);
        set_fields(1, c[1], a[1], d[1]);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        wait_acks(1'b1, 1'b1, 1'b0);
    endtask

    // Engine model: answers each transaction according to plan_q; also fires
    // stray m_done pulses while m_enable is low, which must be ignored.
    initial begin : engine
        bit    active = 0;
        int    cnt    = 0;
        plan_t p      = '{0, 32'd0};
        bus.m_done  = 1'b0;
        bus.m_rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.m_done = 1'b0;
            if (rst) begin
                active = 0;
            end else if (bus.m_enable) begin
                if (!active) begin
                    active = 1;
                    cnt    = 0;
                    if (plan_q.size() > 0) p = plan_q.pop_front();
                    else                   p = '{0, 32'd0};
                end
                cnt++;
                if (cnt == p.lat) begin bus.m_done = 1'b1; bus.m_rdata = p.rdata; end
                else bus.m_rdata = $urandom;
            end else begin
                active = 0;
                if ($urandom_range(0, 7) == 0) begin bus.m_done = 1'b1; bus.m_rdata = $urandom; end
            end
        end
    end

    // Monitor: engine transactions, gaps, high lengths and acks against the queues.
    initial begin : monitor
        bit   prev_en   = 0;
        bit   seen_fall = 0;
        bit   have      = 0;
        int   hi        = 0;
        int   lo        = 0;
        txn_t cur;
        ack_t a;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 0; seen_fall = 0; have = 0; hi = 0; lo = 0;
                continue;
            end
            if (bus.m_enable && !prev_en) begin
                hi = 0;
                if (exp_txn_q.size() == 0) begin
                    check("unexpected_txn", 64'd1, 64'd0);
                end else begin
                    cur  = exp_txn_q.pop_front();
                    have = 1;
                    check("m_commands", 64'(bus.m_commands), 64'(cur.cmd));
                    check("m_address",  64'(bus.m_address),  64'(cur.addr));
                    check("m_data_out", 64'(bus.m_data_out), 64'(cur.data));
                    if (seen_fall) begin
                        if (cur.gap_exact) check("gap_exact", 64'(lo), 64'(GAP));
                        else               check("gap_min", 64'(lo >= GAP), 64'd1);
                    end
                end
            end
            if (bus.m_enable) hi++;
            if (!bus.m_enable && prev_en) begin
                seen_fall = 1;
                lo = 0;
                if (have && cur.hi_len >= 0) check("hi_len", 64'(hi), 64'(cur.hi_len));
                have = 0;
            end
            if (!bus.m_enable) lo++;
            prev_en = bus.m_enable;

            if (bus.ack0 && bus.ack1) check("dual_ack", 64'd1, 64'd0);
            if (bus.ack0 || bus.ack1) begin
                if (exp_ack_q.size() == 0) begin
                    check("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    a = exp_ack_q.pop_front();
                    check("ack_id", 64'(bus.ack1), 64'(a.id));
                    if (a.id) begin
                        check("err1",   64'(bus.err1),   64'(a.err));
                        check("rdata1", 64'(bus.rdata1), 64'(a.rdata));
                    end else begin
                        check("err0",   64'(bus.err0),   64'(a.err));
                        check("rdata0", 64'(bus.rdata0), 64'(a.rdata));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int budget;
        logic [7:0] c;
        model_rdata[0] = 32'd0;
        model_rdata[1] = 32'd0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        set_fields(0, 8'd0, 24'd0, 32'd0);
        set_fields(1, 8'd0, 24'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_m_enable",   64'(bus.m_enable),   64'd0);
        check("rst_m_commands", 64'(bus.m_commands), 64'd0);
        check("rst_m_address",  64'(bus.m_address),  64'd0);
        check("rst_m_data_out", 64'(bus.m_data_out), 64'd0);
        check("rst_acks",       64'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 64'd0);
        check("rst_rdata",      64'({bus.rdata0, bus.rdata1}), 64'd0);

        // Contention from reset: order 0,1,0,1.
        model_last = 1;
        c = 8'h03;
        expect_req(0, c, 24'h000111, 32'h0, 10, 12, 32'hA0A0A0A0);
        expect_req(1, c, 24'h000222, 32'h0, 10, 7,  32'hB1B1B1B1);
        set_fields(0, c, 24'h000111, 32'h0);
        set_fields(1, c, 24'h000222, 32'h0);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_acks(1'b1, 1'b1, 1'b0);
        do_pair(8'h0B, PROG, 9, 15);

        // Directed: single read, program insertion.
        do_single(0, 8'h03, 24'h456FAB, 32'h0, 1, 40, 32'hDEADBEEF);
        do_single(1, PROG, 24'h258AFA, 32'h1234AADD, 20, 30, 32'h55AA55AA);

        // Timeout, then a normal request, then done exactly on the timeout cycle.
        do_single(0, 8'h03, 24'h000ABC, 32'h0, 1, 0, 32'h11111111);
        do_single(0, 8'h0B, 24'h000DEF, 32'h0, 1, 5, 32'h22222222);
        do_single(0, 8'h03, 24'h000123, 32'h0, 1, TMO, 32'hCAFEF00D);
        // Write-enable timing out skips the program transfer.
        do_single(1, PROG, 24'h0F0F0F, 32'h99999999, 0, 10, 32'h33333333);

        // Randomised mix of singles and contended pairs.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0)
                do_pair(($urandom_range(0, 2) == 0) ? PROG : 8'($urandom),
                        ($urandom_range(0, 2) == 0) ? PROG : 8'($urandom),
                        $urandom_range(1, 50), $urandom_range(1, 50));
            else
                do_single($urandom_range(0, 1),
                          ($urandom_range(0, 2) == 0) ? PROG : 8'($urandom),
                          24'($urandom), $urandom,
                          $urandom_range(1, 40), $urandom_range(1, 60), $urandom);
        end

        // Async reset in the middle of requester 1's transfer, both requesting.
        do_single(0, 8'h03, 24'h000777, 32'h0, 1, 3, 32'h77777777);
        @(negedge clk);
        set_fields(0, 8'h0B, 24'h00AAAA, 32'h0);
        set_fields(1, 8'h03, 24'h00BBBB, 32'h0);
        exp_txn_q.push_back('{8'h03, 24'h00BBBB, 32'h0, -1, 1'b0});
        plan_q.push_back('{0, 32'd0});
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        budget = 100;
        while (!bus.m_enable && budget > 0) begin @(negedge clk); budget--; end
        check("reset_test_started", 64'(bus.m_enable), 64'd1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_m_enable", 64'(bus.m_enable), 64'd0);
        check("async_rst_state",    64'(state_dbg),    64'd0);
        check("async_rst_rdata0",   64'(bus.rdata0),   64'd0);
        repeat (2) @(negedge clk);
        model_rdata[0] = 32'd0;
        model_rdata[1] = 32'd0;
        model_last = 1;
        expect_req(0, 8'h0B, 24'h00AAAA, 32'h0, 1, 8,  32'h0BADC0DE);
        expect_req(1, 8'h03, 24'h00BBBB, 32'h0, 1, 11, 32'h600DF00D);
        rst = 1'b0;
        wait_acks(1'b1, 1'b1, 1'b0);

        repeat (GAP + 6) @(negedge clk);
        check("txn_queue_drained",  64'(exp_txn_q.size()), 64'd0);
        check("ack_queue_drained",  64'(exp_ack_q.size()), 64'd0);
        check("plan_queue_drained", 64'(plan_q.size()),    64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
